register_file_sb: RTL and testbench
===================================

// Module: register_file_sb
// PURPOSE
//  Parametrised integer register file with NRD read ports and a per-register busy scoreboard.
//  Sits between decode/issue and writeback of the pipelined core.
//  Issue marks the destination register busy; writeback stores data and clears busy.
//  Decode reads operands and busy flags to detect RAW hazards and stall.
// PARAMETERS
//  XLEN   32  register data width in bits
//  NREGS  32  number of architectural registers; power of 2, >=2; AW = $clog2(NREGS)
//  NRD    2   number of read ports, 1..4
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         asynchronous active-low reset
//  rs_addr      in   NRD*AW    read addresses; port k = [k*AW +: AW]
//  rs_data      out  NRD*XLEN  read data; port k = [k*XLEN +: XLEN]; combinational
//  rs_busy      out  NRD       per-port busy flag for the addressed register; combinational
//  we           in   1         writeback enable
//  rd_addr      in   AW        writeback address
//  rd_data      in   XLEN      writeback data
//  issue_valid  in   1         instruction issued this cycle; mark issue_rd busy
//  issue_rd     in   AW        destination of the issued instruction
//  flush        in   1         pipeline flush; clears all busy bits
//  busy_cnt     out  AW+1      number of busy registers; registered
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers 0, all busy bits 0, busy_cnt 0.
//  - Reset mid-operation discards pending busy state immediately.
//  - Register 0 is hardwired:
//    - reads return 0 and rs_busy=0;
//    - writes to 0 are ignored;
//    - issue_rd=0 never sets busy.
//  - Write: on posedge when we && rd_addr!=0, store rd_data and clear busy[rd_addr].
//  - Issue: on posedge when issue_valid && issue_rd!=0 && !flush, set busy[issue_rd].
//  - Same edge, same register, issue and writeback: data is written and busy ends SET.
//    The new producer wins.
//  - Flush: on posedge, all busy bits clear. A same-edge write still updates data.
//    A same-edge issue is ignored.
//  - busy_cnt always equals popcount(busy) as of the current cycle; max NREGS-1.
//  - Reads: rs_data and rs_busy are combinational from the current array state.
//    All ports are independent and may alias the same address.
//  - No read latency. Write-to-read latency is 1 cycle, unless the bypass feature is enabled.
// CONFIGURATION
//  Macro REGFILE_WRITE_BYPASS_EN.
//  - Defined: if we && rd_addr!=0 && rs_addr[k]==rd_addr, then
//    - rs_data[k]=rd_data in the same cycle;
//    - rs_busy[k]=0, unless issue_valid && issue_rd==rd_addr in the same cycle, in which case rs_busy[k]=1.
//  - Undefined: reads see only stored state; the written value is visible the cycle after the write edge.
//    Busy also clears the cycle after the write edge.
// TESTING
//  1. Reset, then read all 32 addresses on both ports -> data 0, rs_busy 0, busy_cnt 0.
//  2. Write x5=0xDEADBEEF; next cycle rs_addr={5,5} -> both ports 0xDEADBEEF.
//     Write x0=0x1234 -> x0 reads 0.
//  3. Issue rd=7 -> busy[7]=1, busy_cnt=1.
//     Write x7=0x55 -> next cycle busy 0, busy_cnt 0, data 0x55.
//  4. Same cycle: issue rd=9 and write x9=0xA -> data 0xA, busy[9]=1, busy_cnt=1.
//  5. Issue x3, x4, x6; then flush together with issue x8 -> busy_cnt 0, x8 not busy.
//     Stored data is unchanged.
//  6. With REGFILE_WRITE_BYPASS_EN: write x12=0x77 while reading x12 -> rs_data=0x77, rs_busy=0 in the same cycle.
//     Without the macro -> old value, busy as stored.
//  Also: assert rst_n low between clock edges while x1 is busy -> busy_cnt 0 immediately.

Source files
------------

// File: rtl/register_file_sb.sv
// register_file_sb: XLEN-wide register file with NRD combinational read ports and a busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_WRITE_BYPASS_EN.
module register_file_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NRD*AW-1:0]   rs_addr,
  output logic [NRD*XLEN-1:0] rs_data,
  output logic [NRD-1:0]      rs_busy,
  input  logic                we,
  input  logic [AW-1:0]       rd_addr,
  input  logic [XLEN-1:0]     rd_data,
  input  logic                issue_valid,
  input  logic [AW-1:0]       issue_rd,
  input  logic                flush,
  output logic [AW:0]         busy_cnt
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;
  logic [AW:0]      r_busy_cnt;
  logic [AW:0]      w_cnt_next;
  logic             w_wr_en;
  logic             w_issue_en;

  assign w_wr_en    = we && (rd_addr != '0);
  assign w_issue_en = issue_valid && (issue_rd != '0) && !flush;

  // Entry 0 is reset to zero and never written, so it reads as the hardwired zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (w_wr_en) begin
      r_regs[rd_addr] <= rd_data;
    end
  end

  // Issue is applied after writeback so a same-register collision leaves the new producer busy.
  always_comb begin
    w_busy_next = r_busy;
    if (flush) begin
      w_busy_next = '0;
    end else begin
      if (w_wr_en)    w_busy_next[rd_addr]  = 1'b0;
      if (w_issue_en) w_busy_next[issue_rd] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_comb begin
    w_cnt_next = '0;
    for (int i = 1; i < NREGS; i++) w_cnt_next = w_cnt_next + {{AW{1'b0}}, w_busy_next[i]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy     <= '0;
      r_busy_cnt <= '0;
    end else begin
      r_busy     <= w_busy_next;
      r_busy_cnt <= w_cnt_next;
    end
  end

  assign busy_cnt = r_busy_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] w_addr;
      assign w_addr = rs_addr[gi*AW +: AW];
`ifdef REGFILE_WRITE_BYPASS_EN
      logic w_hit;
      assign w_hit = w_wr_en && (w_addr == rd_addr);
      assign rs_data[gi*XLEN +: XLEN] = w_hit ? rd_data : r_regs[w_addr];
      assign rs_busy[gi] = w_hit ? (issue_valid && (issue_rd == rd_addr)) : r_busy[w_addr];
`else
      assign rs_data[gi*XLEN +: XLEN] = r_regs[w_addr];
      assign rs_busy[gi] = r_busy[w_addr];
`endif
    end
  endgenerate

endmodule

// File: tb/tb_register_file_sb.sv
// Testbench for register_file_sb: directed scenarios plus randomized traffic against an array model.
module tb_register_file_sb;
  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   rs_addr;
  logic [NRD*XLEN-1:0] rs_data;
  logic [NRD-1:0]      rs_busy;
  logic                we;
  logic [AW-1:0]       rd_addr;
  logic [XLEN-1:0]     rd_data;
  logic                issue_valid;
  logic [AW-1:0]       issue_rd;
  logic                flush;
  logic [AW:0]         busy_cnt;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] m_mem  [NREGS];
  bit              m_busy [NREGS];

  always #5 clk = ~clk;

  register_file_sb #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk(clk), .rst_n(rst_n), .rs_addr(rs_addr), .rs_data(rs_data), .rs_busy(rs_busy),
    .we(we), .rd_addr(rd_addr), .rd_data(rd_data), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .busy_cnt(busy_cnt)
  );

  function automatic void model_reset();
    for (int i = 0; i < NREGS; i++) begin
      m_mem[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endfunction

  // State change at a clock edge, stated from the register-file rules.
  function automatic void model_edge();
    int w = int'(rd_addr);
    int d = int'(issue_rd);
    if (we && w != 0) m_mem[w] = rd_data;
    if (flush) begin
      for (int i = 0; i < NREGS; i++) m_busy[i] = 1'b0;
    end else begin
      if (we && w != 0) m_busy[w] = 1'b0;
      if (issue_valid && d != 0) m_busy[d] = 1'b1;
    end
  endfunction

  function automatic logic [XLEN-1:0] exp_data(input logic [AW-1:0] a);
    if (a == 0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (we && rd_addr != 0 && a == rd_addr) return rd_data;
`endif
    return m_mem[a];
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a);
    if (a == 0) return 1'b0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (we && rd_addr != 0 && a == rd_addr) return issue_valid && (issue_rd == rd_addr);
`endif
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int n = 0;
    for (int i = 0; i < NREGS; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  task automatic idle();
    we = 1'b0; rd_addr = '0; rd_data = '0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rs_addr = {a1, a0};
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    set_rd(0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int a = 0; a < NREGS; a++) begin
      set_rd(AW'(a), AW'(a));
      #1;
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rs_data[k*XLEN +: XLEN] !== '0 || rs_busy[k] !== 1'b0) begin
          errors++;
          $display("FAIL reset_read addr %0d port %0d: got data %h busy %b, expected 0/0",
                   a, k, rs_data[k*XLEN +: XLEN], rs_busy[k]);
        end
      end
    end
    checks++;
    if (busy_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d expected 0", busy_cnt);
    end
    $display("reset: all %0d addresses read, busy_cnt %0d", NREGS, busy_cnt);
  endtask

  task automatic test_write();
    idle(); we = 1'b1; rd_addr = 5; rd_data = 32'hDEADBEEF;
    tick();
    idle(); set_rd(5, 5); #1;
    for (int k = 0; k < NRD; k++) begin
      checks++;
      if (rs_data[k*XLEN +: XLEN] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL write_x5 port %0d: got %h expected deadbeef", k, rs_data[k*XLEN +: XLEN]);
      end
    end
    we = 1'b1; rd_addr = 0; rd_data = 32'h1234;
    tick();
    idle(); set_rd(0, 5); #1;
    checks++;
    if (rs_data[0 +: XLEN] !== '0 || rs_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL write_x0: got %h busy %b expected 0/0", rs_data[0 +: XLEN], rs_busy[0]);
    end
    $display("write: x5=%h x0=%h", rs_data[XLEN +: XLEN], rs_data[0 +: XLEN]);
  endtask

  task automatic test_issue_writeback();
    idle(); issue_valid = 1'b1; issue_rd = 7;
    tick();
    idle(); set_rd(7, 7); #1;
    checks++;
    if (rs_busy !== 2'b11 || busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL issue_x7: got busy %b cnt %0d expected 11 / 1", rs_busy, busy_cnt);
    end
    we = 1'b1; rd_addr = 7; rd_data = 32'h55;
    tick();
    idle(); set_rd(7, 7); #1;
    checks++;
    if (rs_busy !== 2'b00 || busy_cnt !== 6'd0 || rs_data[0 +: XLEN] !== 32'h55) begin
      errors++;
      $display("FAIL wb_x7: got busy %b cnt %0d data %h expected 00 / 0 / 55",
               rs_busy, busy_cnt, rs_data[0 +: XLEN]);
    end
    $display("issue/writeback x7: busy %b cnt %0d data %h", rs_busy, busy_cnt, rs_data[0 +: XLEN]);
  endtask

  task automatic test_same_edge();
    idle(); issue_valid = 1'b1; issue_rd = 9; we = 1'b1; rd_addr = 9; rd_data = 32'hA;
    tick();
    idle(); set_rd(9, 9); #1;
    checks++;
    if (rs_data[XLEN +: XLEN] !== 32'hA || rs_busy !== 2'b11 || busy_cnt !== 6'd1) begin
      errors++;
      $display("FAIL same_edge_x9: got data %h busy %b cnt %0d expected a / 11 / 1",
               rs_data[XLEN +: XLEN], rs_busy, busy_cnt);
    end
    $display("same edge x9: data %h busy %b cnt %0d", rs_data[XLEN +: XLEN], rs_busy, busy_cnt);
  endtask

  task automatic test_flush();
    logic [AW-1:0] regs [3] = '{5'd3, 5'd4, 5'd6};
    for (int i = 0; i < 3; i++) begin
      idle(); issue_valid = 1'b1; issue_rd = regs[i];
      tick();
    end
    idle(); #1;
    checks++;
    if (int'(busy_cnt) !== exp_cnt()) begin
      errors++;
      $display("FAIL pre_flush_cnt: got %0d expected %0d", busy_cnt, exp_cnt());
    end
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 8;
    tick();
    idle(); set_rd(8, 3); #1;
    checks++;
    if (busy_cnt !== '0 || rs_busy !== 2'b00) begin
      errors++;
      $display("FAIL flush: got cnt %0d busy %b expected 0 / 00", busy_cnt, rs_busy);
    end
    set_rd(5, 9); #1;
    checks++;
    if (rs_data[0 +: XLEN] !== 32'hDEADBEEF || rs_data[XLEN +: XLEN] !== 32'hA) begin
      errors++;
      $display("FAIL flush_data: got %h %h expected deadbeef 0000000a",
               rs_data[0 +: XLEN], rs_data[XLEN +: XLEN]);
    end
    $display("flush: cnt %0d x5=%h x9=%h", busy_cnt, rs_data[0 +: XLEN], rs_data[XLEN +: XLEN]);
  endtask

  task automatic test_bypass();
    logic [XLEN-1:0] want_d;
    logic            want_b;
    idle(); we = 1'b1; rd_addr = 12; rd_data = 32'h11;
    tick();
    idle(); issue_valid = 1'b1; issue_rd = 12;
    tick();
    idle(); we = 1'b1; rd_addr = 12; rd_data = 32'h77; set_rd(12, 12); #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    want_d = 32'h77; want_b = 1'b0;
`else
    want_d = 32'h11; want_b = 1'b1;
`endif
    for (int k = 0; k < NRD; k++) begin
      checks++;
      if (rs_data[k*XLEN +: XLEN] !== want_d || rs_busy[k] !== want_b) begin
        errors++;
        $display("FAIL bypass_x12 port %0d: got %h busy %b expected %h busy %b",
                 k, rs_data[k*XLEN +: XLEN], rs_busy[k], want_d, want_b);
      end
    end
    tick();
    idle(); #1;
    checks++;
    if (rs_data[0 +: XLEN] !== 32'h77 || rs_busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL after_write_x12: got %h busy %b expected 77 / 0", rs_data[0 +: XLEN], rs_busy[0]);
    end
    $display("bypass x12: same-cycle expected %h/%b, after edge %h/%b", want_d, want_b,
             rs_data[0 +: XLEN], rs_busy[0]);
  endtask

  task automatic test_random();
    int errs_before = errors;
    for (int n = 0; n < 400; n++) begin
      we          = 1'($urandom_range(0, 1));
      rd_addr     = AW'($urandom_range(0, NREGS - 1));
      rd_data     = $urandom;
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = ($urandom_range(0, 3) == 0) ? rd_addr : AW'($urandom_range(0, NREGS - 1));
      flush       = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NRD; k++)
        rs_addr[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? rd_addr : AW'($urandom_range(0, NREGS - 1));
      #1;
      for (int k = 0; k < NRD; k++) begin
        checks++;
        if (rs_data[k*XLEN +: XLEN] !== exp_data(rs_addr[k*AW +: AW]) ||
            rs_busy[k] !== exp_busy(rs_addr[k*AW +: AW])) begin
          errors++;
          $display("FAIL random_read cycle %0d port %0d addr %0d: got %h/%b expected %h/%b",
                   n, k, rs_addr[k*AW +: AW], rs_data[k*XLEN +: XLEN], rs_busy[k],
                   exp_data(rs_addr[k*AW +: AW]), exp_busy(rs_addr[k*AW +: AW]));
        end
      end
      checks++;
      if (int'(busy_cnt) !== exp_cnt()) begin
        errors++;
        $display("FAIL random_cnt cycle %0d: got %0d expected %0d", n, busy_cnt, exp_cnt());
      end
      tick();
    end
    idle();
    $display("random: 400 cycles, %0d new errors", errors - errs_before);
  endtask

  task automatic test_async_reset();
    idle(); issue_valid = 1'b1; issue_rd = 1;
    tick();
    idle(); set_rd(1, 5); #1;
    checks++;
    if (rs_busy[0] !== 1'b1 || int'(busy_cnt) !== exp_cnt()) begin
      errors++;
      $display("FAIL pre_async_x1: got busy %b cnt %0d expected 1 / %0d", rs_busy[0], busy_cnt, exp_cnt());
    end
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (busy_cnt !== '0 || rs_busy !== 2'b00 || rs_data !== '0) begin
      errors++;
      $display("FAIL async_reset: got cnt %0d busy %b data %h expected 0 / 00 / 0",
               busy_cnt, rs_busy, rs_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    $display("async reset mid-cycle: cnt %0d busy %b", busy_cnt, rs_busy);
  endtask

  initial begin
    idle();
    set_rd(0, 0);
    test_reset();
    test_write();
    test_issue_writeback();
    test_same_edge();
    test_flush();
    test_bypass();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
